vga_receiver: RTL and testbench

- Sink end of the 640x480@60 VGA link: samples vga_hs/vga_vs/vga_r/g/b on the 25 MHz pixel clock.
- Recovers horizontal and vertical position, checks sync timing against parameters and declares lock.
- When locked, emits a pixel stream with x/y coordinates.
- Used as an on-chip loopback checker for the VGA controller and as a capture front end.

---
 rtl/vga_receiver.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_receiver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_receiver.sv
// VGA sink: rebuilds raster position from hs/vs, validates sync timing, locks and streams active pixels.
// Pins are registered once (stage A), and every output is registered one edge after that.
module vga_receiver #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk25MHz,
  input  logic        rst_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] err_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int GW      = $clog2(LOCK_FRAMES + 2);

  localparam logic [10:0]   H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0]   H_SYNC_END  = 11'(H_SYNC);
  localparam logic [10:0]   H_ACT_FIRST = 11'(H_SYNC + H_BACK);
  localparam logic [10:0]   H_ACT_LAST  = 11'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0]    V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_ACT_FIRST = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]    V_ACT_LAST  = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Stage A (pins) and stage B (previous sync levels)
  logic       a_hs_q, a_vs_q, b_hs_q, b_vs_q;
  logic [7:0] a_r_q, a_g_q, a_b_q;

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        vs_pend_q, vs_pend_d;
  logic        err_seen_q, err_seen_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic        frame_start_q, frame_start_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  state_t      state_q;
  logic [GW-1:0] good_q, good_inc;
  logic        locked_q;

  logic hs_fall, hs_rise, vs_fall, boundary, err_now, saturated;
  logic h_act, v_act;

  assign hs_fall  = b_hs_q & ~a_hs_q;
  assign hs_rise  = ~b_hs_q & a_hs_q;
  assign vs_fall  = b_vs_q & ~a_vs_q;
  // A vs fall landing on the same cycle as the hs fall closes the frame right away.
  assign boundary = hs_fall & (vs_pend_q | vs_fall);
  assign good_inc = good_q + 1'b1;

  always_comb begin
    hcnt_d = hs_fall ? 11'd0 : ((hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1);

    vcnt_d = vcnt_q;
    if (boundary) begin
      vcnt_d = 10'd0;
    end else if (hs_fall && vcnt_q != 10'h3FF) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    vs_pend_d = boundary ? 1'b0 : (vs_pend_q | vs_fall);

    h_err_d = (state_q != SEARCH) &&
              ((hs_fall && hcnt_q != H_LAST) || (hs_rise && hcnt_d != H_SYNC_END));
    v_err_d = (state_q != SEARCH) && boundary && (vcnt_q != V_LAST);
    err_now = h_err_d | v_err_d;

    err_seen_d = boundary ? 1'b0 : (err_seen_q | err_now);
    saturated  = (hcnt_d == 11'h7FF) || (vcnt_d == 10'h3FF);

    h_act = (hcnt_d >= H_ACT_FIRST) && (hcnt_d <= H_ACT_LAST);
    v_act = (vcnt_d >= V_ACT_FIRST) && (vcnt_d <= V_ACT_LAST);
    pix_valid_d = h_act && v_act && locked_q;

    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    pix_r_d = pix_r_q;
    pix_g_d = pix_g_q;
    pix_b_d = pix_b_q;
    if (pix_valid_d) begin
      pix_x_d = 10'(hcnt_d - H_ACT_FIRST);
      pix_y_d = vcnt_d - V_ACT_FIRST;
      pix_r_d = a_r_q;
      pix_g_d = a_g_q;
      pix_b_d = a_b_q;
    end

    frame_start_d = pix_valid_d && (hcnt_d == H_ACT_FIRST) && (vcnt_d == V_ACT_FIRST);

    err_cnt_d = (err_now && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      a_hs_q        <= 1'b1;
      a_vs_q        <= 1'b1;
      b_hs_q        <= 1'b1;
      b_vs_q        <= 1'b1;
      a_r_q         <= 8'd0;
      a_g_q         <= 8'd0;
      a_b_q         <= 8'd0;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 10'd0;
      vs_pend_q     <= 1'b0;
      err_seen_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      pix_r_q       <= 8'd0;
      pix_g_q       <= 8'd0;
      pix_b_q       <= 8'd0;
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      err_cnt_q     <= 16'd0;
    end else begin
      a_hs_q        <= vga_hs;
      a_vs_q        <= vga_vs;
      b_hs_q        <= a_hs_q;
      b_vs_q        <= a_vs_q;
      a_r_q         <= vga_r;
      a_g_q         <= vga_g;
      a_b_q         <= vga_b;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      vs_pend_q     <= vs_pend_d;
      err_seen_q    <= err_seen_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      frame_start_q <= frame_start_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Lock tracker: a frame counts as clean only if no violation was seen since the last boundary.
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      locked_q <= (state_q == LOCKED);
      if (saturated) begin
        state_q <= SEARCH;
        good_q  <= '0;
      end else begin
        case (state_q)
          SEARCH: begin
            if (boundary) begin
              state_q <= ACQUIRE;
              good_q  <= '0;
            end
          end
          ACQUIRE: begin
            if (boundary) begin
              if (!err_seen_q && !err_now) begin
                good_q <= good_inc;
                if (good_inc >= GOOD_TARGET) begin
                  state_q <= LOCKED;
                end
              end else begin
                good_q <= '0;
              end
            end
          end
          LOCKED: begin
            if (err_now) begin
              state_q <= ACQUIRE;
              good_q  <= '0;
            end
          end
          default: begin
            state_q <= SEARCH;
            good_q  <= '0;
          end
        endcase
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_vga_receiver.sv
// Scoreboard bench for vga_receiver on a shrunken raster (34x13 total) so that many frames fit in a short run.
module tb_vga_receiver;

  localparam int HV = 16, HF = 4, HS = 8, HB = 6;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_hs, vga_vs;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        pix_valid, frame_start, locked, h_err, v_err;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [15:0] err_count;

  always #20 clk = ~clk;

  vga_receiver #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .clk25MHz(clk), .rst_n(rst_n),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  logic [43:0] sb[$];
  int pv_cnt, fs_cnt, exp_cnt;
  int herr_cnt = 0, verr_cnt = 0;
  int herr_cyc = 0, verr_cyc = 0, lfall_cyc = 0, lrise_cyc = 0;
  int t_frame;
  bit exp_on = 1'b0;
  bit prev_locked = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      pv_cnt++;
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0)
        check("pixel", 64'({pix_x, pix_y, pix_r, pix_g, pix_b}), 64'(sb.pop_front()));
    end
    if (frame_start === 1'b1) begin
      fs_cnt++;
      check("fs_xy", 64'({pix_valid, pix_x, pix_y}), 64'({1'b1, 20'd0}));
    end
    if (h_err === 1'b1) begin herr_cnt++; herr_cyc = cyc; end
    if (v_err === 1'b1) begin verr_cnt++; verr_cyc = cyc; end
    if (prev_locked && locked === 1'b0) lfall_cyc = cyc;
    if (!prev_locked && locked === 1'b1) lrise_cyc = cyc;
    prev_locked = (locked === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vga_hs = 1'b1; vga_vs = 1'b1;
    vga_r = 8'd0; vga_g = 8'd0; vga_b = 8'd0;
    repeat (n) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix"}, 64'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b}), 64'd0);
    check({tag, "_flags"}, 64'({frame_start, locked, h_err, v_err}), 64'd0);
    check({tag, "_errcnt"}, 64'(err_count), 64'd0);
  endtask

  // One raster: short_ln loses its last clock, rst_ln pulses reset in the back porch of that line.
  task automatic drive_frame(input int nlines, input int short_ln, input int rst_ln, input bit valid_frame);
    int len;
    bit act;
    logic [7:0] x8, y8;
    pv_cnt = 0; fs_cnt = 0; exp_cnt = 0;
    exp_on = valid_frame;
    t_frame = cyc;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        act = (h >= HA) && (h < HA + HV) && (ln >= VA) && (ln < VA + VV);
        x8 = 8'(h - HA);
        y8 = 8'(ln - VA);
        vga_hs = (h >= HS);
        vga_vs = (ln >= VS);
        if (act) begin
          vga_r = x8; vga_g = y8; vga_b = 8'hA5;
          if (exp_on) begin
            sb.push_back({10'(h - HA), 10'(ln - VA), x8, y8, 8'hA5});
            exp_cnt++;
          end
        end else begin
          vga_r = 8'd0; vga_g = 8'd0; vga_b = 8'd0;
        end
        rst_n = !(ln == rst_ln && h == HS + 2);
        step();
        if (!rst_n) begin
          check_all_zero("midreset");
          rst_n = 1'b1;
          exp_on = 1'b0;
        end
      end
    end
    check("pv_count", 64'(pv_cnt), 64'(exp_cnt));
    check("fs_count", 64'(fs_cnt), valid_frame ? 64'd1 : 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Clean acquisition: lock one edge after the third boundary is processed.
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b0);
    check("lock_pre", 64'(locked), 64'd0);
    drive_frame(VT, -1, -1, 1'b1);
    check("lock_rise_cyc", 64'(lrise_cyc), 64'(t_frame + 3));
    check("hold_last", 64'({pix_x, pix_y, pix_r, pix_g, pix_b}),
          64'({10'(HV - 1), 10'(VV - 1), 8'(HV - 1), 8'(VV - 1), 8'hA5}));
    check("errcnt_clean", 64'(err_count), 64'd0);

    // Short line while locked.
    drive_frame(VT, VT - 2, -1, 1'b1);
    check("herr_pulses", 64'(herr_cnt), 64'd1);
    check("errcnt_h", 64'(err_count), 64'd1);
    check("lock_fall_after_herr", 64'(lfall_cyc - herr_cyc), 64'd1);
    check("lock_after_herr", 64'(locked), 64'd0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b1);
    check("relock_h", 64'(locked), 64'd1);

    // Frame one line short.
    drive_frame(VT - 1, -1, -1, 1'b1);
    drive_frame(VT, -1, -1, 1'b0);
    check("verr_pulses", 64'(verr_cnt), 64'd1);
    check("errcnt_v", 64'(err_count), 64'd2);
    check("lock_fall_after_verr", 64'(lfall_cyc - verr_cyc), 64'd1);
    check("lock_after_verr", 64'(locked), 64'd0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b1);
    check("relock_v", 64'(locked), 64'd1);

    // Sync loss: hcnt saturates and the receiver falls back to search.
    idle(3000);
    check("lock_gap", 64'(locked), 64'd0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b1);
    check("relock_gap", 64'(locked), 64'd1);
    check("errcnt_gap", 64'(err_count), 64'd2);
    check("herr_gap", 64'(herr_cnt), 64'd1);

    // Mid-line reset while locked.
    drive_frame(VT, -1, VA + 2, 1'b1);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b1);
    check("relock_rst", 64'(locked), 64'd1);
    check("errcnt_rst", 64'(err_count), 64'd0);

    idle(4);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
